// File: rtl/fetch_stream_unit_pkg.sv
// Shared defaults and encodings for the fetch front end.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fetch_stream_unit_pkg;

  localparam int DEF_BUNDLE_W    = 60;
  localparam int DEF_PC_W        = 16;
  localparam int DEF_NUM_ENTRIES = 128;
  localparam int DEF_QUEUE_DEPTH = 4;

  // Redirect direction as driven on redirect_dir_i.
  typedef enum logic {
    REDIR_BWD = 1'b0,
    REDIR_FWD = 1'b1
  } redir_dir_e;

endpackage

// File: rtl/fetch_stream_unit_queue.sv
// Generic synchronous FIFO with clear; head is combinational from storage (zero when empty).
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: no full flag; the producer must hold credits so a push never lands on a full queue.
module fetch_stream_unit_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_fire;
  logic             pop_fire;

  assign head_vld  = (count != '0);
  assign head_dat  = head_vld ? mem[rd_ptr] : '0;
  // Clear dominates both push and pop so a squash edge leaves the queue empty.
  assign push_fire = push_vld && !clear_i;
  assign pop_fire  = pop_rdy && head_vld && !clear_i;

  // Store the pushed entry at the write pointer.
  always_ff @(posedge clock_i) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stream_unit.sv
// Instruction-fetch front end: PC generation, sync-read i-mem, decoupling queue to parse (FETCH_PC_TAG_EN adds out_pc_o).
// Latency: bundle at PC visible on out_valid_o two edges after it is issued (one read edge, one push edge).
// Backpressure: out_valid_o/out_ready_i; issue stalls when queue occupancy plus in-flight read reaches QUEUE_DEPTH.
module fetch_stream_unit
  import fetch_stream_unit_pkg::*;
#(
  parameter int BUNDLE_W    = DEF_BUNDLE_W,
  parameter int PC_W        = DEF_PC_W,
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic                redirect_i,
  input  logic [PC_W-1:0]     redirect_base_i,
  input  logic [PC_W-1:0]     redirect_offset_i,
  input  logic                redirect_dir_i,
  input  logic                imem_we_i,
  input  logic [PC_W-1:0]     imem_waddr_i,
  input  logic [BUNDLE_W-1:0] imem_wdata_i,
  input  logic                out_ready_i,
  output logic                out_valid_o,
  output logic [BUNDLE_W-1:0] out_data_o
`ifdef FETCH_PC_TAG_EN
  ,
  output logic [PC_W-1:0]     out_pc_o
`endif
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [PC_W-1:0]  NUM_ENTRIES_PC = PC_W'(NUM_ENTRIES);
  localparam logic [CNT_W-1:0] DEPTH_C        = CNT_W'(QUEUE_DEPTH);

`ifdef FETCH_PC_TAG_EN
  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [BUNDLE_W-1:0] data;
  } entry_t;
`else
  typedef struct packed {
    logic [BUNDLE_W-1:0] data;
  } entry_t;
`endif

  logic [BUNDLE_W-1:0] imem [NUM_ENTRIES];
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     redirect_target;
  logic                rd_vld;
  entry_t              rd_entry;
  logic                squash;
  logic                issue_vld;
  logic                pc_in_range;
  logic                q_push_vld;
  logic                q_pop_rdy;
  logic                q_head_vld;
  entry_t              q_head_dat;
  logic [CNT_W-1:0]    q_count;

  // Relative redirect target, wrapping modulo 2^PC_W in either direction.
  always_comb begin
    redirect_target = (redir_dir_e'(redirect_dir_i) == REDIR_FWD)
                    ? (redirect_base_i + redirect_offset_i)
                    : (redirect_base_i - redirect_offset_i);
  end

  // Credits are counted against pre-pop occupancy, so a same-cycle pop never funds an issue.
  assign squash      = flush_i || redirect_i;
  assign issue_vld   = !squash && ((q_count + CNT_W'(rd_vld)) < DEPTH_C);
  assign pc_in_range = (pc < NUM_ENTRIES_PC);
  assign q_push_vld  = rd_vld && !squash;
  assign q_pop_rdy   = out_ready_i && !squash;

  // Runtime i-mem write port; a same-edge read of the line sees the old contents.
  always_ff @(posedge clock_i) begin
    if (imem_we_i && (imem_waddr_i < NUM_ENTRIES_PC)) begin
      imem[imem_waddr_i[IDX_W-1:0]] <= imem_wdata_i;
    end
  end

  // PC: redirect loads the target, flush holds, otherwise advance on each issued read.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pc <= '0;
    end else if (redirect_i) begin
      pc <= redirect_target;
    end else if (issue_vld) begin
      pc <= pc + PC_W'(1);
    end
  end

  // Read register: holds the single in-flight bundle; squash drops it because issue_vld is low.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_vld   <= 1'b0;
      rd_entry <= '0;
    end else begin
      rd_vld <= issue_vld;
      if (issue_vld) begin
        rd_entry.data <= pc_in_range ? imem[pc[IDX_W-1:0]] : '0;
`ifdef FETCH_PC_TAG_EN
        rd_entry.pc   <= pc;
`endif
      end
    end
  end

  fetch_stream_unit_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_queue (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clear_i  (squash),
    .push_vld (q_push_vld),
    .push_dat (rd_entry),
    .pop_rdy  (q_pop_rdy),
    .head_vld (q_head_vld),
    .head_dat (q_head_dat),
    .count    (q_count)
  );

  assign out_valid_o = q_head_vld;
  assign out_data_o  = q_head_dat.data;
`ifdef FETCH_PC_TAG_EN
  assign out_pc_o    = q_head_dat.pc;
`endif

endmodule

// File: tb/tb_fetch_stream_unit.sv
// Self-checking bench for fetch_stream_unit against a transaction-queue reference model.
// Latency: model tracks issued bundles, which become visible one edge after issue.
// Backpressure: out_ready_i driven directed and randomized.
module tb_fetch_stream_unit;

  localparam int BW = 60;
  localparam int PW = 16;
  localparam int NE = 128;
  localparam int QD = 4;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          flush_i;
  logic          redirect_i;
  logic [PW-1:0] redirect_base_i;
  logic [PW-1:0] redirect_offset_i;
  logic          redirect_dir_i;
  logic          imem_we_i;
  logic [PW-1:0] imem_waddr_i;
  logic [BW-1:0] imem_wdata_i;
  logic          out_ready_i;
  logic          out_valid_o;
  logic [BW-1:0] out_data_o;
`ifdef FETCH_PC_TAG_EN
  logic [PW-1:0] out_pc_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: every issued-but-not-consumed bundle in order; vis=0 means still in the read stage.
  typedef struct {
    logic [PW-1:0] pc;
    logic [BW-1:0] data;
    bit            vis;
  } item_t;

  item_t         mq[$];
  logic [PW-1:0] mpc;
  logic [BW-1:0] mmem [NE];

  fetch_stream_unit dut (
    .clock_i           (clock_i),
    .reset_i           (reset_i),
    .flush_i           (flush_i),
    .redirect_i        (redirect_i),
    .redirect_base_i   (redirect_base_i),
    .redirect_offset_i (redirect_offset_i),
    .redirect_dir_i    (redirect_dir_i),
    .imem_we_i         (imem_we_i),
    .imem_waddr_i      (imem_waddr_i),
    .imem_wdata_i      (imem_wdata_i),
    .out_ready_i       (out_ready_i),
    .out_valid_o       (out_valid_o),
    .out_data_o        (out_data_o)
`ifdef FETCH_PC_TAG_EN
    ,
    .out_pc_o          (out_pc_o)
`endif
  );

  initial forever #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mread(input logic [PW-1:0] a);
    if (int'(a) < NE) return mmem[a[$clog2(NE)-1:0]];
    return '0;
  endfunction

  function automatic logic [BW-1:0] rnd_bundle();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[BW-1:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    mpc = '0;
  endtask

  // One clock edge of the model, using the inputs as they stood before the edge.
  task automatic model_edge();
    bit hv;
    int n;
    if (reset_i) begin
      model_reset();
    end else if (redirect_i) begin
      mq.delete();
      mpc = redirect_dir_i ? (redirect_base_i + redirect_offset_i)
                           : (redirect_base_i - redirect_offset_i);
    end else if (flush_i) begin
      mq.delete();
    end else begin
      n  = mq.size();
      hv = (n > 0) && mq[0].vis;
      if (hv && out_ready_i) void'(mq.pop_front());
      foreach (mq[i]) mq[i].vis = 1'b1;
      if (n < QD) begin
        mq.push_back('{pc: mpc, data: mread(mpc), vis: 1'b0});
        mpc = mpc + 16'd1;
      end
    end
    if (imem_we_i && int'(imem_waddr_i) < NE) mmem[imem_waddr_i[$clog2(NE)-1:0]] = imem_wdata_i;
  endtask

  task automatic check_out(input string tag);
    bit ev;
    ev = (mq.size() > 0) && mq[0].vis;
    chk({tag, "_vld"}, 64'(out_valid_o), 64'(ev));
    if (ev) begin
      chk({tag, "_dat"}, 64'(out_data_o), 64'(mq[0].data));
`ifdef FETCH_PC_TAG_EN
      chk({tag, "_pc"}, 64'(out_pc_o), 64'(mq[0].pc));
`endif
    end
  endtask

  task automatic step(input string tag);
    @(posedge clock_i);
    model_edge();
    @(negedge clock_i);
    check_out(tag);
  endtask

  task automatic do_redirect(input logic [PW-1:0] base, input logic [PW-1:0] off, input logic dir);
    redirect_i        = 1'b1;
    redirect_base_i   = base;
    redirect_offset_i = off;
    redirect_dir_i    = dir;
    step("redir");
    redirect_i        = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; redirect_i = 1'b0;
    redirect_base_i = '0; redirect_offset_i = '0; redirect_dir_i = 1'b0;
    imem_we_i = 1'b0; imem_waddr_i = '0; imem_wdata_i = '0; out_ready_i = 1'b0;
    model_reset();

    // Load the whole i-mem while in reset: lines 0..5 = A0..A5, rest random.
    for (int i = 0; i < NE; i++) begin
      imem_we_i    = 1'b1;
      imem_waddr_i = PW'(i);
      imem_wdata_i = (i < 6) ? BW'(32'hA0 + i) : rnd_bundle();
      step("load");
    end
    imem_we_i = 1'b0;
    chk("rst_vld", 64'(out_valid_o), 64'(0));
    chk("rst_dat", 64'(out_data_o), 64'(0));
`ifdef FETCH_PC_TAG_EN
    chk("rst_pc", 64'(out_pc_o), 64'(0));
`endif

    // Sequential stream, first valid after the second edge post-release.
    reset_i = 1'b0; out_ready_i = 1'b1;
    step("t1");
    chk("t1_lat_edge1", 64'(out_valid_o), 64'(0));
    step("t1");
    chk("t1_first_vld", 64'(out_valid_o), 64'(1));
    chk("t1_first_dat", 64'(out_data_o), 64'hA0);
    repeat (5) step("t1");
    chk("t1_last_dat", 64'(out_data_o), 64'hA5);

    // Backpressure: stall ten cycles, head stable, then gap-free resume.
    out_ready_i = 1'b0;
    repeat (10) step("t2_stall");
    chk("t2_head_hold", 64'(out_data_o), 64'hA5);
    out_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step("t2_resume");
      chk("t2_gapfree_vld", 64'(out_valid_o), 64'(1));
      chk("t2_gapfree_dat", 64'(out_data_o), 64'(mmem[6 + k]));
    end

    // Forward and backward relative redirects.
    do_redirect(16'd10, 16'd5, 1'b1);
    chk("t3_fwd_e0", 64'(out_valid_o), 64'(0));
    step("t3");
    chk("t3_fwd_e1", 64'(out_valid_o), 64'(0));
    step("t3");
    chk("t3_fwd_vld", 64'(out_valid_o), 64'(1));
    chk("t3_fwd_dat", 64'(out_data_o), 64'(mmem[15]));
    do_redirect(16'd10, 16'd5, 1'b0);
    step("t3"); step("t3");
    chk("t3_bwd_dat", 64'(out_data_o), 64'(mmem[5]));

    // Backward wrap to 0xFFFE: out-of-range lines read as zero, then wrap to 0.
    do_redirect(16'd2, 16'd4, 1'b0);
    step("t4"); step("t4");
    chk("t4_wrap_vld", 64'(out_valid_o), 64'(1));
    chk("t4_wrap_dat", 64'(out_data_o), 64'(0));
`ifdef FETCH_PC_TAG_EN
    chk("t4_wrap_pc", 64'(out_pc_o), 64'hFFFE);
`endif
    step("t4"); step("t4");
    chk("t4_after_wrap", 64'(out_data_o), 64'(mmem[0]));

    // Flush and redirect together: redirect wins.
    flush_i = 1'b1;
    do_redirect(16'd20, 16'd3, 1'b1);
    flush_i = 1'b0;
    step("t5"); step("t5");
    chk("t5_redir_wins", 64'(out_data_o), 64'(mmem[23]));
    // Flush alone for three cycles, then resume from the held PC.
    flush_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("t5_flush");
      chk("t5_flush_novld", 64'(out_valid_o), 64'(0));
    end
    flush_i = 1'b0;
    step("t5_resume"); step("t5_resume");
    chk("t5_resume_vld", 64'(out_valid_o), 64'(1));

    // Randomized traffic: ready, redirects, flushes and i-mem writes.
    for (int i = 0; i < 400; i++) begin
      out_ready_i       = ($urandom_range(0, 3) != 0);
      redirect_i        = ($urandom_range(0, 19) == 0);
      flush_i           = ($urandom_range(0, 19) == 0);
      redirect_base_i   = PW'($urandom_range(0, 140));
      redirect_offset_i = PW'($urandom_range(0, 30));
      redirect_dir_i    = 1'($urandom_range(0, 1));
      imem_we_i         = ($urandom_range(0, 4) == 0);
      imem_waddr_i      = PW'($urandom_range(0, 160));
      imem_wdata_i      = rnd_bundle();
      step("rand");
    end
    redirect_i = 1'b0; flush_i = 1'b0; imem_we_i = 1'b0; out_ready_i = 1'b1;

    // Asynchronous reset mid-stream: valid drops without a clock edge.
    repeat (4) step("t6_stream");
    chk("t6_pre_vld", 64'(out_valid_o), 64'(1));
    #2 reset_i = 1'b1;
    #1;
    chk("t6_async_vld", 64'(out_valid_o), 64'(0));
    chk("t6_async_dat", 64'(out_data_o), 64'(0));
    model_reset();
    step("t6_rst"); step("t6_rst");
    reset_i = 1'b0;
    step("t6_restart"); step("t6_restart");
    chk("t6_restart_vld", 64'(out_valid_o), 64'(1));
    chk("t6_restart_dat", 64'(out_data_o), 64'(mmem[0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
